// File: rtl/out_port_arbiter_if.sv
// Handshake and status bundle between the requesters, the arbiter and the downstream link.
// The arbiter connects through the master modport; the surrounding fabric uses slave.
interface out_port_arbiter_if #(
   parameter int unsigned N     = 5,
   parameter int unsigned WIDTH = 11,
   parameter int unsigned IDW   = 3,
   parameter int unsigned CNTW  = 16
);
   logic [N-1:0]       in_req;
   logic [N-1:0]       in_ack;
   logic [N*WIDTH-1:0] in_data;
   logic [N*IDW-1:0]   in_id;
   logic [N-1:0]       en_mask;
   logic               out_req;
   logic               out_ack;
   logic [WIDTH-1:0]   out_data;
   logic [IDW-1:0]     out_id;
   logic [N-1:0]       grant;
   logic               busy;
   logic [CNTW-1:0]    pkt_count;

   modport master (
      input  in_req, in_data, in_id, en_mask, out_ack,
      output in_ack, out_req, out_data, out_id, grant, busy, pkt_count
   );

   modport slave (
      output in_req, in_data, in_id, en_mask, out_ack,
      input  in_ack, out_req, out_data, out_id, grant, busy, pkt_count
   );
endinterface

// File: rtl/out_port_arbiter.sv
// Round-robin arbiter sharing one router output link between N 4-phase requesters.
// Each transfer: grant/ack input, wait input release, request output, wait output release.
module out_port_arbiter #(
   parameter int unsigned N     = 5,
   parameter int unsigned WIDTH = 11,
   parameter int unsigned IDW   = 3,
   parameter int unsigned CNTW  = 16
) (
   input logic              CLK,
   input logic              RESET,
   out_port_arbiter_if.master bus
);
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_IN_ACK,
      ST_OUT_REQ,
      ST_OUT_REL
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    last_q, last_d;
   logic [IW-1:0]    gidx_q, gidx_d;
   logic [N-1:0]     in_ack_q, in_ack_d;
   logic [N-1:0]     grant_q, grant_d;
   logic             out_req_q, out_req_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [IDW-1:0]   out_id_q, out_id_d;
   logic [CNTW-1:0]  pkt_count_q, pkt_count_d;

   logic [N-1:0]     eligible;
   logic [IW-1:0]    win;
   logic             found;
   logic [31:0]      idx;

   assign eligible = bus.in_req & bus.en_mask;

   // Cyclic search starting just after the previous owner.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = (32'(last_q) + k) % N;
         if (!found && eligible[idx[IW-1:0]]) begin
            found = 1'b1;
            win   = idx[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      gidx_d      = gidx_q;
      in_ack_d    = in_ack_q;
      grant_d     = grant_q;
      out_req_d   = out_req_q;
      out_data_d  = out_data_q;
      out_id_d    = out_id_q;
      pkt_count_d = pkt_count_q;
      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               gidx_d        = win;
               out_data_d    = bus.in_data[win*WIDTH +: WIDTH];
               out_id_d      = bus.in_id[win*IDW +: IDW];
               in_ack_d      = '0;
               in_ack_d[win] = 1'b1;
               grant_d       = '0;
               grant_d[win]  = 1'b1;
               state_d       = ST_IN_ACK;
            end
         end
         ST_IN_ACK: begin
            if (!bus.in_req[gidx_q]) begin
               in_ack_d  = '0;
               out_req_d = 1'b1;
               state_d   = ST_OUT_REQ;
            end
         end
         ST_OUT_REQ: begin
            if (bus.out_ack) begin
               out_req_d = 1'b0;
               state_d   = ST_OUT_REL;
            end
         end
         ST_OUT_REL: begin
            if (!bus.out_ack) begin
               last_d      = gidx_q;
               pkt_count_d = pkt_count_q + CNTW'(1);
               grant_d     = '0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         last_q      <= IW'(N - 1);
         gidx_q      <= '0;
         in_ack_q    <= '0;
         grant_q     <= '0;
         out_req_q   <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         pkt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         gidx_q      <= gidx_d;
         in_ack_q    <= in_ack_d;
         grant_q     <= grant_d;
         out_req_q   <= out_req_d;
         out_data_q  <= out_data_d;
         out_id_q    <= out_id_d;
         pkt_count_q <= pkt_count_d;
      end
   end

   assign bus.in_ack    = in_ack_q;
   assign bus.grant     = grant_q;
   assign bus.out_req   = out_req_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
   assign bus.pkt_count = pkt_count_q;
   assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: single request, round robin, masking, stall,
// counter wrap (CNTW=4) and asynchronous reset during a transfer.
module tb_out_port_arbiter;
   localparam int unsigned N     = 5;
   localparam int unsigned WIDTH = 11;
   localparam int unsigned IDW   = 3;
   localparam int unsigned CNTW  = 4;

   logic CLK;
   logic RESET;

   out_port_arbiter_if #(.N(N), .WIDTH(WIDTH), .IDW(IDW), .CNTW(CNTW)) bus ();

   out_port_arbiter #(.N(N), .WIDTH(WIDTH), .IDW(IDW), .CNTW(CNTW)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.master)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [WIDTH-1:0] dat [N];
   logic [IDW-1:0]   ids [N];
   logic [CNTW-1:0]  exp_cnt;

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transfer with immediate partners; the owner drops its request once acked.
   task automatic xfer(input int unsigned g, input bit rearm);
      logic [N-1:0] eg;
      eg = '0;
      eg[g] = 1'b1;
      cyc();
      chk("grant", 32'(bus.grant), 32'(eg));
      chk("in_ack", 32'(bus.in_ack), 32'(eg));
      chk("onehot", 32'($onehot(bus.grant)), 32'd1);
      chk("busy", 32'(bus.busy), 32'd1);
      chk("out_data", 32'(bus.out_data), 32'(dat[g]));
      chk("out_id", 32'(bus.out_id), 32'(ids[g]));
      bus.in_req = bus.in_req & ~eg;
      cyc();
      chk("out_req_set", 32'(bus.out_req), 32'd1);
      chk("in_ack_clr", 32'(bus.in_ack), 32'd0);
      bus.out_ack = 1'b1;
      cyc();
      chk("out_req_clr", 32'(bus.out_req), 32'd0);
      bus.out_ack = 1'b0;
      cyc();
      exp_cnt = exp_cnt + 1'b1;
      chk("grant_idle", 32'(bus.grant), 32'd0);
      chk("busy_idle", 32'(bus.busy), 32'd0);
      chk("pkt_count", 32'(bus.pkt_count), 32'(exp_cnt));
      if (rearm) bus.in_req = bus.in_req | eg;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < int'(N); i++) begin
         dat[i] = WIDTH'(11'h101 * (i + 1));
         ids[i] = IDW'(i);
      end
      dat[2] = 11'h5A3;
      ids[2] = 3'b010;

      RESET       = 1'b1;
      bus.in_req  = '0;
      bus.en_mask = 5'b11111;
      bus.out_ack = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         bus.in_data[i*WIDTH +: WIDTH] = dat[i];
         bus.in_id[i*IDW +: IDW]       = ids[i];
      end
      exp_cnt = '0;
      cyc(); cyc();
      RESET = 1'b0;
      cyc();
      chk("rst_in_ack", 32'(bus.in_ack), 32'd0);
      chk("rst_out_req", 32'(bus.out_req), 32'd0);
      chk("rst_grant", 32'(bus.grant), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_count", 32'(bus.pkt_count), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
      chk("rst_id", 32'(bus.out_id), 32'd0);

      // Single request on index 2
      bus.in_req = 5'b00100;
      xfer(2, 1'b0);
      chk("hold_data", 32'(bus.out_data), 32'h5A3);
      chk("hold_id", 32'(bus.out_id), 32'd2);
      chk("single_count", 32'(bus.pkt_count), 32'd1);

      // Resume after index 2: 3 before 1
      bus.in_req = 5'b01010;
      xfer(3, 1'b0);
      xfer(1, 1'b0);

      // Full contention from reset
      RESET = 1'b1;
      cyc();
      RESET = 1'b0;
      exp_cnt = '0;
      bus.in_req = 5'b11111;
      xfer(0, 1'b1);
      xfer(1, 1'b1);
      xfer(2, 1'b1);
      xfer(3, 1'b1);
      xfer(4, 1'b1);
      xfer(0, 1'b1);
      bus.in_req = '0;

      // Masked requester is never granted
      bus.en_mask = 5'b01111;
      bus.in_req  = 5'b10000;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("mask_in_ack", 32'(bus.in_ack), 32'd0);
         chk("mask_busy", 32'(bus.busy), 32'd0);
      end
      bus.en_mask = 5'b11111;
      xfer(4, 1'b0);

      // Stalled output with other requests pending
      bus.in_req = 5'b00001;
      cyc();
      chk("stall_grant", 32'(bus.grant), 32'd1);
      bus.in_req = 5'b00000;
      cyc();
      bus.in_req = 5'b00110;
      for (int i = 0; i < 20; i++) begin
         chk("stall_out_req", 32'(bus.out_req), 32'd1);
         chk("stall_data", 32'(bus.out_data), 32'(dat[0]));
         chk("stall_in_ack", 32'(bus.in_ack), 32'd0);
         cyc();
      end
      bus.out_ack = 1'b1;
      cyc();
      bus.out_ack = 1'b0;
      cyc();
      exp_cnt = exp_cnt + 1'b1;
      chk("stall_count", 32'(bus.pkt_count), 32'(exp_cnt));
      xfer(1, 1'b0);
      xfer(2, 1'b0);

      // Counter wraps after 17 transfers since reset
      for (int i = 0; i < 7; i++) begin
         bus.in_req = 5'b01000;
         xfer(3, 1'b0);
      end
      chk("wrap", 32'(bus.pkt_count), 32'd1);

      // Asynchronous reset while in OUT_REQ
      bus.in_req = 5'b00001;
      cyc();
      bus.in_req = 5'b00000;
      cyc();
      chk("pre_rst_out_req", 32'(bus.out_req), 32'd1);
      #2 RESET = 1'b1;
      #1;
      chk("async_out_req", 32'(bus.out_req), 32'd0);
      chk("async_grant", 32'(bus.grant), 32'd0);
      chk("async_in_ack", 32'(bus.in_ack), 32'd0);
      chk("async_busy", 32'(bus.busy), 32'd0);
      chk("async_count", 32'(bus.pkt_count), 32'd0);
      chk("async_data", 32'(bus.out_data), 32'd0);
      cyc();
      RESET = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
